ahblite_cmd_master: RTL

AHBLITE_CMD_MASTER -- requirements
Module: ahblite_cmd_master

---
 rtl/ahb_pkg.sv | 11 +
 rtl/ahblite_cmd_master.sv | 102 ++++++++++
 2 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings, master FSM states and command legality helper.
package ahb_pkg;
  typedef enum logic [1:0] {HTRANS_IDLE = 2'b00, HTRANS_BUSY = 2'b01, HTRANS_NONSEQ = 2'b10, HTRANS_SEQ = 2'b11} htrans_t;
  typedef enum logic [2:0] {HSIZE_BYTE = 3'd0, HSIZE_HALF = 3'd1, HSIZE_WORD = 3'd2} hsize_t;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  function automatic logic bad_cmd(input logic [1:0] size, input logic [1:0] addr_lo);
    return (size == 2'd3) || (size == 2'd1 && addr_lo[0]) || (size == 2'd2 && addr_lo != 2'd0);
  endfunction
endpackage

// File: rtl/ahblite_cmd_master.sv
// ahblite_cmd_master: single-outstanding command-to-AHB-Lite master; AHB_MASTER_TIMEOUT_EN adds an HREADY stall abort.
module ahblite_cmd_master
  import ahb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [1:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  input  logic        HRESP
);
  state_t state, state_n;
  logic [31:0] addr_r, wdata_r;
  logic [1:0] size_r;
  logic write_r, err_sticky, accept, reject, timeout;
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  assign cmd_ready = (state == IDLE) && !HRESET;
  assign accept = cmd_valid && cmd_ready;
  assign reject = bad_cmd(cmd_size, cmd_addr[1:0]);
  assign rsp_valid = (state == RESP);
  assign HTRANS = (state == ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR = addr_r;
  assign HWRITE = write_r;
  assign HSIZE = {1'b0, size_r};
  assign HBURST = HBURST_SINGLE;
  assign HPROT = HPROT_DEFAULT;
  assign HWDATA = (state == DATA && write_r) ? wdata_r : 32'h0;
`ifdef AHB_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] stall_cnt;
  logic in_bus;
  assign in_bus = (state == ADDR) || (state == DATA);
  assign timeout = in_bus && !HREADY && stall_cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge HCLK)
    stall_cnt <= (HRESET || state_n != state) ? '0 : (in_bus && !HREADY) ? stall_cnt + 1'b1 : stall_cnt;
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = accept ? (reject ? RESP : ADDR) : IDLE;
      ADDR: state_n = timeout ? RESP : HREADY ? DATA : ADDR;
      DATA: state_n = (timeout || HREADY) ? RESP : DATA;
      RESP: state_n = rsp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state      <= IDLE;
      addr_r     <= '0;
      wdata_r    <= '0;
      size_r     <= '0;
      write_r    <= 1'b0;
      err_sticky <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        addr_r     <= cmd_addr;
        wdata_r    <= cmd_wdata;
        size_r     <= cmd_size;
        write_r    <= cmd_write;
        err_sticky <= 1'b0;
        rsp_rdata  <= '0;
        rsp_err    <= reject;
      end
      // an error seen on a stalled cycle must survive until completion
      if (state == DATA && !HREADY && HRESP) err_sticky <= 1'b1;
      if (state == DATA && HREADY) begin
        rsp_err   <= HRESP || err_sticky;
        rsp_rdata <= (write_r || HRESP || err_sticky) ? 32'h0 : HRDATA;
      end
      if (timeout) begin
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end
endmodule
